fbuf_fill_arbiter: RTL and testbench
====================================

# fbuf_fill_arbiter

Owns the framebuffer BRAM write port and shares it between two requesters. The first is the AXI-Lite single-pixel write path. The second is a built-in rectangle-fill sequencer that walks a clipped rectangle and issues one pixel write per granted cycle. It sits between the AXI-Lite GPU register decode and the framebuffer BRAM, and it replaces the direct decode-to-BRAM write connection.

## Interface
- FRAME_WIDTH_SCALED, 640, pixels per framebuffer row
- FRAME_HEIGHT_SCALED, 480, rows in the framebuffer
- FBUF_ADDR_WIDTH, 19, BRAM address width
- FBUF_DATA_WIDTH, 8, BRAM pixel width
- COORD_WIDTH, 12, width of the fill coordinate and size fields
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  single-pixel write request
- pix_ready  out  1  pixel request accepted this cycle when high together with pix_valid
- pix_addr  in  FBUF_ADDR_WIDTH  linear pixel address
- pix_data  in  FBUF_DATA_WIDTH  pixel value
- fill_start  in  1  one-cycle fill command strobe
- fill_x0, fill_y0  in  COORD_WIDTH  top-left corner of the rectangle
- fill_w, fill_h  in  COORD_WIDTH  rectangle width and height
- fill_color  in  FBUF_DATA_WIDTH  fill value
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle completion pulse
- fill_rej  out  1  one-cycle pulse: fill_start arrived while busy and was ignored
- fbuf_rst_busy  in  1  BRAM reset in progress; no writes may be issued
- fbuf_en_wr, fbuf_wrea  out  1  BRAM enable and write-enable (always driven equal)
- fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM address
- fbuf_data  out  FBUF_DATA_WIDTH  BRAM write data

## Operation
- **Reset:** every output is 0, the FSM is IDLE and the priority bit selects pixel. Reset mid-fill abandons the fill; no fill_done is produced.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - fill_start latches the command.
  - Clipping: x_end = min(x0+w, W) and y_end = min(y0+h, H), computed at COORD_WIDTH+1 bits so the sum cannot overflow.
  - If w==0, h==0, x0≥W or y0≥H, the area is empty: go to DONE with no writes.
  - Otherwise go to RUN with x=x0, y=y0 and row_base = y0·W.
- **RUN:**
  - Request the port every cycle.
  - On each grant, write address row_base+x with fill_color, then x++.
  - When x+1 reaches x_end: x=x0, y++, row_base += W (incremental update; no multiplier is needed in the loop).
  - A grant of the last pixel (x=x_end−1, y=y_end−1) moves the FSM to DONE.
- **DONE:** one cycle with fill_done=1, then back to IDLE.
- **fill_busy:** 1 in RUN and DONE.
- **fill_start outside IDLE:** ignored, fill_rej pulses the next cycle, and the command is not queued.
- **Arbitration:**
  - Both requesters are eligible only when fbuf_rst_busy=0.
  - With only one requester, it wins.
  - With both, the requester selected by the priority bit wins, and the bit toggles after every contended grant (strict alternation).
  - An uncontended grant leaves the bit unchanged.
- **pix_ready:** combinational = !fbuf_rst_busy && (pixel wins). It does not depend on pix_valid when fill is not in RUN.
- **Out-of-range pixel:** a pixel with pix_addr ≥ W·H is accepted (handshake completes) but dropped; fbuf_en_wr stays 0.
- **Priority with fill idle:** the priority bit is irrelevant outside RUN; pixel writes are back-to-back at full rate.

## Timing
- **Output registers:** all fbuf_* outputs are registered. A grant in cycle N produces fbuf_en_wr=1 with addr/data in cycle N+1. In a cycle with no grant, fbuf_en_wr=0 and addr/data are 0.
- **Fill start:** fill_start accepted in cycle N puts the FSM in RUN at N+1. The first fill write can appear at N+2.
- **Fill done:** fill_done coincides with the cycle the last fill write is on fbuf_*. For an empty fill, fill_done occurs at N+1. fill_busy falls the cycle after fill_done.
- **Throughput:** an uncontended fill writes 1 pixel/cycle, so w·h pixels take w·h cycles in RUN. Under continuous pixel traffic each side gets 1 write every 2 cycles.
- **fbuf_rst_busy=1:** grants stop in the same cycle and fbuf_en_wr=0 the next cycle. The fill position is held and resumes without loss. Pixel requests stay pending with pix_ready=0.
- **fill_start with pix_valid:** both are accepted in the same cycle; they are independent.

## Test plan
- **Reset:** assert rst mid-RUN → all outputs 0 asynchronously, no fill_done after release, next fill_start accepted normally.
- **Basic fill:** fill x0=2, y0=1, w=3, h=2, color=0x5A, no pixel traffic → writes to 642, 643, 644, 1282, 1283, 1284 in 6 consecutive cycles starting N+2; fill_done with the 1284 write.
- **Clipping:** fill x0=638, y0=479, w=5, h=5 → exactly 2 writes, 307198 and 307199. Fill x0=640 → no writes, fill_done at N+1.
- **Contention:** fill w=4, h=1 at 0,0 with pix_valid held (addr 1000, 1001, …) → writes alternate pixel 1000, fill 0, pixel 1001, fill 1, …; no pixel lost or duplicated.
- **BRAM reset stall:** fbuf_rst_busy=1 for 3 cycles in the middle of a 10-pixel fill → 3-cycle gap in writes, all 10 addresses written once, fill_done 3 cycles later than unstalled.
- **Busy reject and out-of-range pixel:** fill_start during RUN → fill_rej pulse, running fill unaffected. pix_addr=307200 → pix_ready=1, no BRAM write.

Source files
------------

// File: rtl/fbuf_fill_arbiter.sv
// Framebuffer BRAM write-port owner: arbitrates AXI-Lite pixel writes against a
// rectangle-fill sequencer, with strict alternation when both contend.
module fbuf_fill_arbiter #(
   parameter int FRAME_WIDTH_SCALED  = 640,
   parameter int FRAME_HEIGHT_SCALED = 480,
   parameter int FBUF_ADDR_WIDTH     = 19,
   parameter int FBUF_DATA_WIDTH     = 8,
   parameter int COORD_WIDTH         = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pix_valid,
   output logic                       pix_ready,
   input  logic [FBUF_ADDR_WIDTH-1:0] pix_addr,
   input  logic [FBUF_DATA_WIDTH-1:0] pix_data,
   input  logic                       fill_start,
   input  logic [COORD_WIDTH-1:0]     fill_x0,
   input  logic [COORD_WIDTH-1:0]     fill_y0,
   input  logic [COORD_WIDTH-1:0]     fill_w,
   input  logic [COORD_WIDTH-1:0]     fill_h,
   input  logic [FBUF_DATA_WIDTH-1:0] fill_color,
   output logic                       fill_busy,
   output logic                       fill_done,
   output logic                       fill_rej,
   input  logic                       fbuf_rst_busy,
   output logic                       fbuf_en_wr,
   output logic                       fbuf_wrea,
   output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
   output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);
   localparam int CW1 = COORD_WIDTH + 1;
   localparam logic [CW1-1:0] W_C = CW1'(FRAME_WIDTH_SCALED);
   localparam logic [CW1-1:0] H_C = CW1'(FRAME_HEIGHT_SCALED);
   localparam logic [FBUF_ADDR_WIDTH-1:0] NPIX =
      FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED * FRAME_HEIGHT_SCALED);
   localparam logic [FBUF_ADDR_WIDTH-1:0] ROW_STEP = FBUF_ADDR_WIDTH'(FRAME_WIDTH_SCALED);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state_q, state_d;
   logic [COORD_WIDTH-1:0]     x_q, x_d, y_q, y_d, x0_q, x0_d;
   logic [CW1-1:0]             x_end_q, x_end_d, y_end_q, y_end_d;
   logic [FBUF_ADDR_WIDTH-1:0] row_q, row_d, addr_q, addr_d;
   logic [FBUF_DATA_WIDTH-1:0] color_q, color_d, data_q, data_d;
   logic                       prio_q, prio_d;   // 0: pixel wins next contention
   logic                       rej_q, rej_d, en_q, en_d;

   logic [CW1-1:0] sum_x, sum_y, clip_x, clip_y;
   logic           empty, fill_req, pix_win, pix_gnt, fill_gnt, x_wrap, last_pix;

   // Sums are one bit wider than the coordinates so clipping never wraps.
   assign sum_x  = {1'b0, fill_x0} + {1'b0, fill_w};
   assign sum_y  = {1'b0, fill_y0} + {1'b0, fill_h};
   assign clip_x = (sum_x > W_C) ? W_C : sum_x;
   assign clip_y = (sum_y > H_C) ? H_C : sum_y;
   assign empty  = (fill_w == '0) || (fill_h == '0) ||
                   ({1'b0, fill_x0} >= W_C) || ({1'b0, fill_y0} >= H_C);

   assign fill_req = (state_q == RUN) && !fbuf_rst_busy;
   assign pix_win  = !fbuf_rst_busy && ((state_q != RUN) || !prio_q);
   assign pix_gnt  = pix_valid && pix_win;
   assign fill_gnt = fill_req && !pix_gnt;
   assign x_wrap   = ({1'b0, x_q} + CW1'(1)) == x_end_q;
   assign last_pix = x_wrap && (({1'b0, y_q} + CW1'(1)) == y_end_q);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      x0_d    = x0_q;
      x_end_d = x_end_q;
      y_end_d = y_end_q;
      row_d   = row_q;
      color_d = color_q;
      prio_d  = prio_q;
      rej_d   = 1'b0;
      en_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;

      if (pix_gnt && (pix_addr < NPIX)) begin
         en_d   = 1'b1;
         addr_d = pix_addr;
         data_d = pix_data;
      end
      if (fill_req && pix_valid) prio_d = !prio_q;

      unique case (state_q)
         IDLE: if (fill_start) begin
            x0_d    = fill_x0;
            x_d     = fill_x0;
            y_d     = fill_y0;
            x_end_d = clip_x;
            y_end_d = clip_y;
            row_d   = FBUF_ADDR_WIDTH'(fill_y0) * ROW_STEP;
            color_d = fill_color;
            state_d = empty ? DONE : RUN;
         end
         RUN: begin
            rej_d = fill_start;
            if (fill_gnt) begin
               en_d   = 1'b1;
               addr_d = row_q + FBUF_ADDR_WIDTH'(x_q);
               data_d = color_q;
               if (x_wrap) begin
                  x_d   = x0_q;
                  y_d   = y_q + COORD_WIDTH'(1);
                  row_d = row_q + ROW_STEP;
               end else begin
                  x_d = x_q + COORD_WIDTH'(1);
               end
               if (last_pix) state_d = DONE;
            end
         end
         DONE: begin
            rej_d   = fill_start;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         x0_q    <= '0;
         x_end_q <= '0;
         y_end_q <= '0;
         row_q   <= '0;
         color_q <= '0;
         prio_q  <= 1'b0;
         rej_q   <= 1'b0;
         en_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         x0_q    <= x0_d;
         x_end_q <= x_end_d;
         y_end_q <= y_end_d;
         row_q   <= row_d;
         color_q <= color_d;
         prio_q  <= prio_d;
         rej_q   <= rej_d;
         en_q    <= en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Held low during reset so every output reads 0 while rst is asserted.
   assign pix_ready  = pix_win && !rst;
   assign fill_busy  = (state_q != IDLE);
   assign fill_done  = (state_q == DONE);
   assign fill_rej   = rej_q;
   assign fbuf_en_wr = en_q;
   assign fbuf_wrea  = en_q;
   assign fbuf_addr  = addr_q;
   assign fbuf_data  = data_q;
endmodule

// File: tb/tb_fbuf_fill_arbiter.sv
// Bench for fbuf_fill_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the fill/arbitration rules.
module tb_fbuf_fill_arbiter;
   localparam int W = 640, H = 480, AW = 19, DW = 8, CW = 12;

   logic clk = 1'b0, rst = 1'b1;
   logic pix_valid = 1'b0, fill_start = 1'b0, fbuf_rst_busy = 1'b0;
   logic [AW-1:0] pix_addr = '0;
   logic [DW-1:0] pix_data = '0, fill_color = '0;
   logic [CW-1:0] fill_x0 = '0, fill_y0 = '0, fill_w = '0, fill_h = '0;
   logic pix_ready, fill_busy, fill_done, fill_rej, fbuf_en_wr, fbuf_wrea;
   logic [AW-1:0] fbuf_addr;
   logic [DW-1:0] fbuf_data;

   fbuf_fill_arbiter dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_addr(pix_addr), .pix_data(pix_data), .fill_start(fill_start),
      .fill_x0(fill_x0), .fill_y0(fill_y0), .fill_w(fill_w), .fill_h(fill_h),
      .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
      .fill_rej(fill_rej), .fbuf_rst_busy(fbuf_rst_busy), .fbuf_en_wr(fbuf_en_wr),
      .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0, done_cyc = -1;
   int fq[$];                 // fill addresses still to be written
   bit m_run = 0, m_done = 0, m_prio = 0, m_pg = 0, obs_rej = 0, obs_pr = 0;
   logic [DW-1:0] m_color = '0;
   logic [31:0] e_out = '0;   // {en, wrea, addr, data, done, busy, rej}
   int wlog[$], wcyc[$];

   task automatic model_reset();
      m_run = 0; m_done = 0; m_prio = 0; m_color = '0; e_out = '0;
      fq.delete();
   endtask

   // One clock: check DUT against the model, advance the model, move to next negedge.
   task automatic step();
      bit rb, exp_pr, fg, en, nd, rj;
      int a, xe, ye;
      logic [DW-1:0] d;
      #1; cyc++;
      total++;
      if ({fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data, fill_done, fill_busy, fill_rej} !== e_out) begin
         bad++;
         $display("FAIL outputs cyc=%0d got=%h want=%h", cyc,
                  {fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data, fill_done, fill_busy, fill_rej}, e_out);
      end
      rb = fbuf_rst_busy;
      exp_pr = !rb && (!m_run || !m_prio);
      total++;
      if (pix_ready !== exp_pr) begin
         bad++; $display("FAIL pix_ready cyc=%0d got=%b want=%b", cyc, pix_ready, exp_pr);
      end
      if (fbuf_en_wr === 1'b1) begin wlog.push_back(int'(fbuf_addr)); wcyc.push_back(cyc); end
      if (fill_done === 1'b1) done_cyc = cyc;
      obs_rej = (fill_rej === 1'b1);
      obs_pr  = (pix_ready === 1'b1);

      m_pg = pix_valid && exp_pr;
      fg = m_run && !rb && !m_pg;
      en = 0; a = 0; d = '0;
      if (m_pg && int'(pix_addr) < W * H) begin en = 1; a = int'(pix_addr); d = pix_data; end
      if (fg) begin en = 1; a = fq.pop_front(); d = m_color; end
      if (m_run && pix_valid && !rb) m_prio = !m_prio;
      rj = fill_start && (m_run || m_done);
      nd = 0;
      if (fg && fq.size() == 0) begin
         m_run = 0; nd = 1;
      end else if (fill_start && !m_run && !m_done) begin
         xe = (int'(fill_x0) + int'(fill_w) > W) ? W : int'(fill_x0) + int'(fill_w);
         ye = (int'(fill_y0) + int'(fill_h) > H) ? H : int'(fill_y0) + int'(fill_h);
         for (int yy = int'(fill_y0); yy < ye; yy++)
            for (int xx = int'(fill_x0); xx < xe; xx++) fq.push_back(yy * W + xx);
         m_color = fill_color;
         if (fq.size() == 0) nd = 1; else m_run = 1;
      end
      m_done = nd;
      e_out = {en, en, AW'(a), d, nd, (m_run || nd), rj};
      @(posedge clk); @(negedge clk);
   endtask

   task automatic start_fill(input int x0, input int y0, input int w, input int h,
                             input logic [DW-1:0] c, output int n);
      fill_x0 = CW'(x0); fill_y0 = CW'(y0); fill_w = CW'(w); fill_h = CW'(h);
      fill_color = c; fill_start = 1'b1;
      step();
      n = cyc;
      fill_start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (m_run || m_done); i++) step();
      total++;
      if (m_run || m_done) begin bad++; $display("FAIL drain timeout cyc=%0d", cyc); end
      step();
   endtask

   task automatic clear_logs();
      wlog.delete(); wcyc.delete(); done_cyc = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk); #1;
      total++;
      if ({pix_ready, fill_busy, fill_done, fill_rej, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data} !== '0) begin
         bad++; $display("FAIL reset_outputs got=%h want=0",
            {pix_ready, fill_busy, fill_done, fill_rej, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data});
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step();
   endtask

   task automatic test_basic_fill();
      int n;
      int exp[6] = '{642, 643, 644, 1282, 1283, 1284};
      clear_logs();
      start_fill(2, 1, 3, 2, 8'h5A, n);
      for (int i = 0; i < 8; i++) step();
      total++;
      if (wlog.size() != 6) begin bad++; $display("FAIL basic_count got=%0d want=6", wlog.size()); end
      else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (wlog[i] != exp[i] || wcyc[i] != n + 2 + i) begin
               bad++; $display("FAIL basic_write%0d got=%0d@%0d want=%0d@%0d", i, wlog[i], wcyc[i], exp[i], n + 2 + i);
            end
         end
      end
      total++;
      if (done_cyc != n + 7) begin bad++; $display("FAIL basic_done got=%0d want=%0d", done_cyc, n + 7); end
   endtask

   task automatic test_clipping();
      int n;
      clear_logs();
      start_fill(638, 479, 5, 5, 8'hC3, n);
      for (int i = 0; i < 5; i++) step();
      total++;
      if (wlog.size() != 2 || wlog[0] != 307198 || wlog[1] != 307199) begin
         bad++; $display("FAIL clip_writes got_n=%0d want 307198,307199", wlog.size());
      end
      clear_logs();
      start_fill(640, 0, 4, 4, 8'h11, n);
      for (int i = 0; i < 3; i++) step();
      total++;
      if (done_cyc != n + 1 || wlog.size() != 0) begin
         bad++; $display("FAIL clip_empty got done=%0d writes=%0d want done=%0d writes=0", done_cyc, wlog.size(), n + 1);
      end
   endtask

   task automatic test_contention();
      int n, np;
      int exp[8] = '{1000, 0, 1001, 1, 1002, 2, 1003, 3};
      clear_logs();
      np = 0;
      start_fill(0, 0, 4, 1, 8'h33, n);
      for (int i = 0; i < 8; i++) begin
         pix_valid = 1'b1; pix_addr = AW'(1000 + np); pix_data = DW'(np + 1);
         step();
         if (m_pg) np++;
      end
      pix_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      total++;
      if (wlog.size() != 8) begin bad++; $display("FAIL contend_count got=%0d want=8", wlog.size()); end
      else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (wlog[i] != exp[i]) begin bad++; $display("FAIL contend_write%0d got=%0d want=%0d", i, wlog[i], exp[i]); end
         end
      end
   endtask

   task automatic test_stall();
      int n;
      clear_logs();
      start_fill(5, 3, 10, 1, 8'h7E, n);
      for (int i = 1; i <= 16; i++) begin
         fbuf_rst_busy = (i >= 4 && i <= 6);
         step();
      end
      fbuf_rst_busy = 1'b0;
      total++;
      if (done_cyc != n + 14) begin bad++; $display("FAIL stall_done got=%0d want=%0d", done_cyc, n + 14); end
      total++;
      if (wlog.size() != 10) begin bad++; $display("FAIL stall_count got=%0d want=10", wlog.size()); end
      else begin
         for (int i = 0; i < 10; i++) begin
            total++;
            if (wlog[i] != 1925 + i) begin bad++; $display("FAIL stall_write%0d got=%0d want=%0d", i, wlog[i], 1925 + i); end
         end
      end
   endtask

   task automatic test_reject_oor();
      int n;
      clear_logs();
      start_fill(0, 10, 6, 1, 8'h99, n);
      step();
      fill_start = 1'b1; fill_x0 = '0; fill_y0 = '0; fill_w = 12'd1; fill_h = 12'd1;
      step();
      fill_start = 1'b0;
      step();
      total++;
      if (!obs_rej) begin bad++; $display("FAIL reject_pulse got=0 want=1"); end
      drain();
      total++;
      if (wlog.size() != 6 || wlog[0] != 6400 || wlog[5] != 6405) begin
         bad++; $display("FAIL reject_fill got_n=%0d want 6400..6405", wlog.size());
      end
      clear_logs();
      pix_valid = 1'b1; pix_addr = AW'(W * H); pix_data = 8'hFF;
      step();
      total++;
      if (!obs_pr) begin bad++; $display("FAIL oor_ready got=0 want=1"); end
      pix_valid = 1'b0;
      step(); step();
      total++;
      if (wlog.size() != 0) begin bad++; $display("FAIL oor_write got=%0d want=0", wlog.size()); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         pix_valid     = ($urandom_range(0, 2) != 0);
         pix_addr      = AW'($urandom_range(0, W * H + 200));
         pix_data      = DW'($urandom);
         fbuf_rst_busy = ($urandom_range(0, 9) == 0);
         fill_start    = ($urandom_range(0, 15) == 0);
         fill_x0       = CW'($urandom_range(0, W + 10));
         fill_y0       = CW'($urandom_range(0, H + 10));
         if ($urandom_range(0, 3) == 0) begin
            fill_x0 = CW'(W - $urandom_range(0, 4)); fill_y0 = CW'(H - $urandom_range(0, 4));
         end
         fill_w        = CW'($urandom_range(0, 9));
         fill_h        = CW'($urandom_range(0, 4));
         fill_color    = DW'($urandom);
         step();
      end
      pix_valid = 1'b0; fill_start = 1'b0; fbuf_rst_busy = 1'b0;
      drain();
   endtask

   task automatic test_reset_midfill();
      int n;
      start_fill(0, 5, 20, 2, 8'h42, n);
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      #2;
      total++;
      if ({pix_ready, fill_busy, fill_done, fill_rej, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data} !== '0) begin
         bad++; $display("FAIL midreset_outputs got=%h want=0",
            {pix_ready, fill_busy, fill_done, fill_rej, fbuf_en_wr, fbuf_wrea, fbuf_addr, fbuf_data});
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      clear_logs();
      for (int i = 0; i < 40; i++) step();
      total++;
      if (done_cyc != -1 || wlog.size() != 0) begin
         bad++; $display("FAIL midreset_quiet got done=%0d writes=%0d want none", done_cyc, wlog.size());
      end
      start_fill(1, 0, 2, 1, 8'h24, n);
      for (int i = 0; i < 4; i++) step();
      total++;
      if (done_cyc != n + 3 || wlog.size() != 2 || wlog[0] != 1) begin
         bad++; $display("FAIL midreset_refill got done=%0d writes=%0d want done=%0d writes=2", done_cyc, wlog.size(), n + 3);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_clipping();
      test_contention();
      test_stall();
      test_reject_oor();
      test_random();
      test_reset_midfill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
